de_scoreboard: RTL and testbench

Parametrised register-busy scoreboard for the decode stage. It replaces per-stage destination-register comparisons with per-register in-flight writer counters: increment on issue out of DE, decrement on writeback. Sits beside the DE latch; drives the DE→FE stall and gates the DE latch load. Supports multiple source operands, multiple writeback ports, and optional same-cycle writeback bypass.

---
 rtl/de_scoreboard_pkg.sv | 15 +
 rtl/de_sb_cnt.sv | 40 ++++
 rtl/de_scoreboard.sv | 111 +++++++++++
 tb/tb_de_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/de_scoreboard_pkg.sv
// Shared constants and helpers for the decode-stage register-busy scoreboard.
package de_scoreboard_pkg;

  localparam int unsigned DEF_NREGS     = 32;
  localparam int unsigned DEF_REGNOBITS = 5;

  typedef logic [31:0] stat_cnt_t;
  localparam stat_cnt_t STAT_CNT_MAX = '1;

  // Width that holds cnt+inc and any writeback hit count without wrapping.
  function automatic int unsigned sum_width(int unsigned cntbits, int unsigned wbw);
    return ((cntbits > wbw) ? cntbits : wbw) + 1;
  endfunction

endpackage

// File: rtl/de_sb_cnt.sv
// One register's in-flight writer counter: +inc on issue, -wbhit on writeback,
// clamped at zero with an underflow pulse.
module de_sb_cnt
  import de_scoreboard_pkg::*;
#(
  parameter int unsigned CNTBITS = 2,
  parameter int unsigned WBW     = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc,
  input  logic [WBW-1:0]     wbhit,
  output logic [CNTBITS-1:0] cnt,
  output logic               busy,
  output logic               underflow
);

  localparam int unsigned SW = sum_width(CNTBITS, WBW);

  logic [SW-1:0] sum;
  logic [SW-1:0] wb_ext;
  logic [SW-1:0] cnt_next;

  always_comb begin
    sum       = SW'(cnt) + SW'(inc);
    wb_ext    = SW'(wbhit);
    underflow = (wb_ext > sum);
    cnt_next  = underflow ? '0 : (sum - wb_ext);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch clears them without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_next[CNTBITS-1:0];
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage scoreboard: per-register writer counters drive the DE stall
// and the DE latch load, with optional same-cycle writeback bypass.
module de_scoreboard
  import de_scoreboard_pkg::*;
#(
  parameter int unsigned NREGS     = DEF_NREGS,
  parameter int unsigned REGNOBITS = DEF_REGNOBITS,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned NWB       = 1,
  parameter int unsigned CNTBITS   = 2,
  parameter bit          BYPASS_WB = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic                      kill,
  input  logic [NSRC-1:0]           src_valid,
  input  logic [NSRC*REGNOBITS-1:0] src_regno,
  input  logic                      dst_valid,
  input  logic [REGNOBITS-1:0]      dst_regno,
  input  logic [NWB-1:0]            wb_valid,
  input  logic [NWB*REGNOBITS-1:0]  wb_regno,
  output logic                      stall,
  output logic                      issue_fire,
  output logic [NREGS-1:0]          busy_vec,
  output stat_cnt_t                 stall_cycles,
  output logic                      err_underflow
);

  localparam int unsigned WBW = $clog2(NWB + 1);
  localparam int unsigned SW  = sum_width(CNTBITS, WBW);
  localparam logic [CNTBITS-1:0] CNT_MAX = '1;

  logic [CNTBITS-1:0] cnt   [NREGS];
  logic [WBW-1:0]     wbhit [NREGS];
  logic [NREGS-1:0]   busy_eff;
  logic [NREGS-1:1]   inc;
  logic [NREGS-1:1]   uf;
  logic               src_hazard;
  logic               sat_hazard;

  // Register 0 is hardwired idle; no counter is built for it.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    de_sb_cnt #(
      .CNTBITS (CNTBITS),
      .WBW     (WBW)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc[r]),
      .wbhit     (wbhit[r]),
      .cnt       (cnt[r]),
      .busy      (busy_vec[r]),
      .underflow (uf[r])
    );
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wbhit[r] = '0;
      for (int p = 0; p < NWB; p++) begin
        if (wb_valid[p] && (wb_regno[p*REGNOBITS +: REGNOBITS] == REGNOBITS'(r)))
          wbhit[r] = wbhit[r] + WBW'(1);
      end
    end
  end

  // A writeback that retires every in-flight writer hides the busy bit when bypassing.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      busy_eff[r] = (cnt[r] != '0);
      if (BYPASS_WB && (SW'(cnt[r]) <= SW'(wbhit[r])))
        busy_eff[r] = 1'b0;
    end
  end

  always_comb begin
    src_hazard = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_valid[i] && busy_eff[src_regno[i*REGNOBITS +: REGNOBITS]])
        src_hazard = 1'b1;
    end
  end

  assign sat_hazard = dst_valid && (dst_regno != '0) &&
                      (cnt[dst_regno] == CNT_MAX) && (wbhit[dst_regno] == '0);

  assign stall      = issue_valid && !kill && (src_hazard || sat_hazard);
  assign issue_fire = issue_valid && !kill && !stall;

  always_comb begin
    for (int r = 1; r < NREGS; r++)
      inc[r] = issue_fire && dst_valid && (dst_regno == REGNOBITS'(r));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (stall && (stall_cycles != STAT_CNT_MAX))
        stall_cycles <= stall_cycles + 32'd1;
      if (|uf)
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed bench for de_scoreboard: bypass and non-bypass instances share stimulus.
module tb_de_scoreboard;

  localparam int NREGS = 32;
  localparam int RB    = 5;
  localparam int NSRC  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid;
  logic            kill;
  logic [NSRC-1:0] src_valid;
  logic [NSRC*RB-1:0] src_regno;
  logic            dst_valid;
  logic [RB-1:0]   dst_regno;
  logic [0:0]      wb_valid;
  logic [RB-1:0]   wb_regno;

  logic             stall_b, fire_b, err_b;
  logic [NREGS-1:0] busy_b;
  logic [31:0]      sc_b;
  logic             stall_n, fire_n, err_n;
  logic [NREGS-1:0] busy_n;
  logic [31:0]      sc_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_scoreboard #(.NREGS(NREGS), .REGNOBITS(RB), .NSRC(NSRC), .NWB(1),
                  .CNTBITS(2), .BYPASS_WB(1'b1)) dut_b (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .kill(kill),
    .src_valid(src_valid), .src_regno(src_regno), .dst_valid(dst_valid),
    .dst_regno(dst_regno), .wb_valid(wb_valid), .wb_regno(wb_regno),
    .stall(stall_b), .issue_fire(fire_b), .busy_vec(busy_b),
    .stall_cycles(sc_b), .err_underflow(err_b)
  );

  de_scoreboard #(.NREGS(NREGS), .REGNOBITS(RB), .NSRC(NSRC), .NWB(1),
                  .CNTBITS(2), .BYPASS_WB(1'b0)) dut_n (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .kill(kill),
    .src_valid(src_valid), .src_regno(src_regno), .dst_valid(dst_valid),
    .dst_regno(dst_regno), .wb_valid(wb_valid), .wb_regno(wb_regno),
    .stall(stall_n), .issue_fire(fire_n), .busy_vec(busy_n),
    .stall_cycles(sc_n), .err_underflow(err_n)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change just after a posedge; checks happen #1 later, far from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic k, input logic [NSRC-1:0] sv,
                       input logic [RB-1:0] s0, input logic [RB-1:0] s1,
                       input logic dv, input logic [RB-1:0] d,
                       input logic wv, input logic [RB-1:0] w);
    issue_valid = iv;
    kill        = k;
    src_valid   = sv;
    src_regno   = {s1, s0};
    dst_valid   = dv;
    dst_regno   = d;
    wb_valid    = wv;
    wb_regno    = w;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    check("rst_busy", busy_b, 32'h0);
    check("rst_stall", stall_b, 0);
    check("rst_fire", fire_b, 1);
    check("rst_stall_cycles", sc_b, 0);
    check("rst_err", err_b, 0);
    drive(1, 1, 2'b00, 0, 0, 0, 0, 0, 0);
    check("rst_fire_kill", fire_b, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    #12;
    reset = 1'b1;
    tick();

    // RAW on x5: bypass instance clears in the wb cycle, the other a cycle later
    drive(1, 0, 2'b00, 0, 0, 1, 5, 0, 0);
    check("raw_issue_fire", fire_b, 1);
    tick();
    drive(1, 0, 2'b01, 5, 0, 0, 0, 0, 0);
    check("raw_busy_b", busy_b, 32'h20);
    check("raw_busy_n", busy_n, 32'h20);
    check("raw_stall_b", stall_b, 1);
    check("raw_stall_n", stall_n, 1);
    tick();
    drive(1, 0, 2'b01, 5, 0, 0, 0, 1, 5);
    check("wb_bypass_stall", stall_b, 0);
    check("wb_bypass_fire", fire_b, 1);
    check("wb_nobypass_stall", stall_n, 1);
    tick();
    drive(1, 0, 2'b01, 5, 0, 0, 0, 0, 0);
    check("wb_busy_b", busy_b, 32'h0);
    check("wb_busy_n", busy_n, 32'h0);
    check("nobypass_stall_drop", stall_n, 0);
    check("nobypass_stall_cycles", sc_n, 2);
    check("bypass_stall_cycles", sc_b, 1);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    tick();

    // WAW saturation on x7
    drive(1, 0, 2'b00, 0, 0, 1, 7, 0, 0);
    tick(); tick(); tick();
    check("waw_busy", busy_b, 32'h80);
    check("sat_stall", stall_b, 1);
    check("sat_fire", fire_b, 0);
    drive(1, 0, 2'b00, 0, 0, 1, 7, 1, 7);
    check("sat_wb_stall", stall_b, 0);
    check("sat_wb_fire", fire_b, 1);
    tick();
    drive(1, 0, 2'b00, 0, 0, 1, 7, 0, 0);
    check("sat_still_max", stall_b, 1);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 7);
    tick(); tick();
    check("drain2_busy", busy_b, 32'h80);
    tick();
    check("drain3_busy", busy_b, 32'h0);
    check("drain_err", err_b, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // Kill beats stall and leaves counters/stats untouched
    drive(1, 0, 2'b00, 0, 0, 1, 3, 0, 0);
    tick();
    drive(1, 1, 2'b01, 3, 0, 1, 3, 0, 0);
    check("kill_stall", stall_b, 0);
    check("kill_fire", fire_b, 0);
    tick();
    check("kill_stall_cycles", sc_b, 1);
    check("kill_busy", busy_b, 32'h8);
    drive(1, 0, 2'b01, 3, 0, 1, 3, 0, 0);
    check("nokill_stall", stall_b, 1);
    tick();
    check("stall_cycles_2", sc_b, 2);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 3);
    tick();
    check("kill_no_inc", busy_b, 32'h0);
    check("kill_err", err_b, 0);

    // x0 writeback is harmless; x9 writeback with nothing in flight is an underflow
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
    tick();
    check("wb_x0_err", err_b, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 1, 9);
    tick();
    check("uf_err", err_b, 1);
    check("uf_busy", busy_b, 32'h0);
    drive(1, 0, 2'b00, 0, 0, 1, 0, 0, 0);
    check("x0_dst_fire", fire_b, 1);
    tick();
    check("uf_sticky", err_b, 1);
    check("x0_dst_busy", busy_b, 32'h0);
    drive(1, 0, 2'b11, 0, 0, 0, 0, 0, 0);
    check("x0_src_stall", stall_b, 0);

    // Async reset mid-stall, hazard seen on source 1
    drive(1, 0, 2'b00, 0, 0, 1, 5, 0, 0);
    tick();
    drive(1, 0, 2'b10, 0, 5, 0, 0, 0, 0);
    check("src1_busy", busy_b, 32'h20);
    check("src1_stall", stall_b, 1);
    tick();
    check("pre_rst_stall_cycles", sc_b, 3);
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", busy_b, 32'h0);
    check("arst_stall", stall_b, 0);
    check("arst_stall_cycles", sc_b, 0);
    check("arst_err", err_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
